// File: rtl/poolb_gen_pkg.sv
// Shared definitions for the generic pooling engine: mode encoding, controller states
// and a width helper that never returns zero.
package poolb_gen_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StWaitNext
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/poolb_gen_lane.sv
// One pooling lane: folds a window's samples into a running max or sum and registers
// the (optionally averaged) result when the window's last sample arrives.
module poolb_gen_lane
    import poolb_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KERNAL_SIZE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  first,
    input  logic                  last,
    input  logic                  mode,
    input  logic                  active,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned SHIFT     = $clog2(KERNAL_SIZE * KERNAL_SIZE);
    localparam int unsigned ACC_WIDTH = DATA_WIDTH + SHIFT;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] sample;
    logic signed [ACC_WIDTH-1:0] merged;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic [DATA_WIDTH-1:0]       result_q;

    assign sample = ACC_WIDTH'($signed(data_in));

    always_comb begin
        merged = sample;
        if (!first) begin
            if (mode == POOL_AVG) begin
                merged = acc_q + sample;
            end else if (acc_q > sample) begin
                merged = acc_q;
            end
        end
        // Arithmetic shift gives floor division for negative sums.
        scaled = (mode == POOL_AVG) ? (merged >>> SHIFT) : merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
        end else if (in_valid) begin
            acc_q <= merged;
            if (last) begin
                result_q <= active ? DATA_WIDTH'(scaled) : '0;
            end
        end
    end

    assign result = result_q;

endmodule

// File: rtl/poolb_gen.sv
// Parametrised pooling engine: walks K x K windows over U channels at a time, one read per
// cycle, and hands the pooled map to the next layer with start/busy handshaking.
module poolb_gen
    import poolb_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned IFM_SIZE        = 10,
    parameter int unsigned IFM_DEPTH       = 16,
    parameter int unsigned KERNAL_SIZE     = 2,
    parameter int unsigned STRIDE          = 2,
    parameter int unsigned NUMBER_OF_UNITS = 1,
    parameter bit          AVG_ENABLE      = 1'b1,
    localparam int unsigned GROUPS =
        (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    localparam int unsigned IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
    localparam int unsigned ADDRESS_SIZE_IFM = clog2_min1(GROUPS * IFM_SIZE * IFM_SIZE),
    localparam int unsigned ADDRESS_SIZE_NEXT_IFM =
        clog2_min1(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    localparam int unsigned SEL_WIDTH = clog2_min1(GROUPS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start_from_previous,
    input  logic                                    pool_mode,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]   data_in_from_previous,
    output logic                                    ifm_enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0]             ifm_address_read_current,
    output logic                                    end_to_previous,
    input  logic                                    conv_ready,
    input  logic                                    end_from_next,
    output logic                                    ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0]        ifm_address_write_next,
    output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0]   data_out_for_next,
    output logic [SEL_WIDTH-1:0]                    ifm_sel_next,
    output logic                                    start_to_next,
    output logic                                    busy
);

    localparam int unsigned RW = clog2_min1(IFM_SIZE_NEXT);
    localparam int unsigned KW = clog2_min1(KERNAL_SIZE);
    localparam int unsigned KK = KERNAL_SIZE * KERNAL_SIZE;

    // The shift-based average is only exact when the window holds a power-of-two count.
    if (AVG_ENABLE && ((KK & (KK - 1)) != 0)) begin : g_avg_check
        $error("average pooling needs KERNAL_SIZE*KERNAL_SIZE to be a power of two");
    end

    state_e state_q, state_d;
    logic   start_pending_q, start_pending_d;
    logic   next_busy_q;
    logic   mode_q;
    logic   go;
    logic   drain_q;
    logic   end_q;

    logic [SEL_WIDTH-1:0] g_q, g_d;
    logic [RW-1:0]        r_q, r_d, c_q, c_d;
    logic [KW-1:0]        i_q, i_d, j_q, j_d;
    logic last_j, last_i, last_c, last_r, last_g, final_read, rd_en;
    logic [31:0] rd_addr_full;
    logic [31:0] pix_addr_full;

    logic                             tag_vld_q, tag_first_q, tag_last_q;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] tag_addr_q;
    logic [SEL_WIDTH-1:0]             tag_grp_q;

    logic                             wr_en_q;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_q;
    logic [SEL_WIDTH-1:0]             sel_q;

    assign rd_en      = (state_q == StRun);
    assign last_j     = (j_q == KW'(KERNAL_SIZE - 1));
    assign last_i     = (i_q == KW'(KERNAL_SIZE - 1));
    assign last_c     = (c_q == RW'(IFM_SIZE_NEXT - 1));
    assign last_r     = (r_q == RW'(IFM_SIZE_NEXT - 1));
    assign last_g     = (g_q == SEL_WIDTH'(GROUPS - 1));
    assign final_read = last_j & last_i & last_c & last_r & last_g;

    // Window walk: j fastest, then i, c, r, g. Counters rest at zero outside RUN.
    always_comb begin
        g_d = g_q;
        r_d = r_q;
        c_d = c_q;
        i_d = i_q;
        j_d = j_q;
        if (rd_en) begin
            j_d = last_j ? '0 : j_q + KW'(1);
            if (last_j) begin
                i_d = last_i ? '0 : i_q + KW'(1);
                if (last_i) begin
                    c_d = last_c ? '0 : c_q + RW'(1);
                    if (last_c) begin
                        r_d = last_r ? '0 : r_q + RW'(1);
                        if (last_r) begin
                            g_d = last_g ? '0 : g_q + SEL_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_addr_full  = 32'(g_q) * IFM_SIZE * IFM_SIZE
                      + (32'(r_q) * STRIDE + 32'(i_q)) * IFM_SIZE
                      + 32'(c_q) * STRIDE + 32'(j_q);
        pix_addr_full = 32'(r_q) * IFM_SIZE_NEXT + 32'(c_q);
    end

    always_comb begin
        state_d         = state_q;
        start_to_next   = 1'b0;
        go              = 1'b0;
        start_pending_d = start_pending_q | start_from_previous;
        unique case (state_q)
            StIdle: begin
                if ((start_from_previous || start_pending_q) && !next_busy_q) begin
                    state_d         = StRun;
                    go              = 1'b1;
                    start_pending_d = 1'b0;
                end
            end
            StRun: begin
                if (final_read) state_d = StDrain;
            end
            StDrain: begin
                if (drain_q) state_d = StWaitNext;
            end
            StWaitNext: begin
                if (conv_ready && !next_busy_q) begin
                    start_to_next = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            start_pending_q <= 1'b0;
            next_busy_q     <= 1'b0;
            mode_q          <= POOL_MAX;
            drain_q         <= 1'b0;
            end_q           <= 1'b0;
            g_q             <= '0;
            r_q             <= '0;
            c_q             <= '0;
            i_q             <= '0;
            j_q             <= '0;
            tag_vld_q       <= 1'b0;
            tag_first_q     <= 1'b0;
            tag_last_q      <= 1'b0;
            tag_addr_q      <= '0;
            tag_grp_q       <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            sel_q           <= '0;
        end else begin
            state_q         <= state_d;
            start_pending_q <= start_pending_d;
            if (start_to_next) begin
                next_busy_q <= 1'b1;
            end else if (end_from_next) begin
                next_busy_q <= 1'b0;
            end
            if (go) begin
                mode_q <= AVG_ENABLE ? pool_mode : POOL_MAX;
            end
            drain_q     <= (state_q == StDrain) & ~drain_q;
            end_q       <= rd_en & final_read;
            g_q         <= g_d;
            r_q         <= r_d;
            c_q         <= c_d;
            i_q         <= i_d;
            j_q         <= j_d;
            tag_vld_q   <= rd_en;
            tag_first_q <= (i_q == '0) && (j_q == '0);
            tag_last_q  <= last_i & last_j;
            tag_addr_q  <= ADDRESS_SIZE_NEXT_IFM'(pix_addr_full);
            tag_grp_q   <= g_q;
            wr_en_q     <= tag_vld_q & tag_last_q;
            if (tag_vld_q && tag_last_q) begin
                wr_addr_q <= tag_addr_q;
                sel_q     <= tag_grp_q;
            end else if (go) begin
                sel_q <= '0;
            end
        end
    end

    for (genvar u = 0; u < NUMBER_OF_UNITS; u++) begin : g_lane
        logic lane_active;
        assign lane_active = (32'(tag_grp_q) * NUMBER_OF_UNITS + u) < IFM_DEPTH;

        poolb_gen_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .KERNAL_SIZE (KERNAL_SIZE)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_valid (tag_vld_q),
            .first    (tag_first_q),
            .last     (tag_last_q),
            .mode     (mode_q),
            .active   (lane_active),
            .data_in  (data_in_from_previous[u*DATA_WIDTH +: DATA_WIDTH]),
            .result   (data_out_for_next[u*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign ifm_enable_read_current  = rd_en;
    assign ifm_address_read_current = rd_en ? ADDRESS_SIZE_IFM'(rd_addr_full) : '0;
    assign end_to_previous          = end_q;
    assign ifm_enable_write_next    = wr_en_q;
    assign ifm_address_write_next   = wr_addr_q;
    assign ifm_sel_next             = sel_q;
    assign busy                     = (state_q != StIdle);

endmodule

// File: tb/tb_poolb_gen.sv
// Bench for poolb_gen: a 2-lane K2/S2 instance and a single-lane K3/S1 max-only instance,
// checked against a window-level reference model, hand tables and handshake sequences.
module tb_poolb_gen;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // Instance A: 4x4 maps, depth 3, two lanes -> two groups, 2x2 output.
    logic        a_start = 1'b0, a_mode = 1'b0, a_conv_ready = 1'b1, a_end_next = 1'b0;
    logic        a_en, a_end, a_wr, a_stn, a_busy;
    logic [4:0]  a_addr;
    logic [1:0]  a_waddr;
    logic [31:0] a_din = '0;
    logic [31:0] a_dout;
    logic [0:0]  a_sel;

    // Instance B: 5x5 map, depth 1, K=3, S=1 -> 3x3 output, max only.
    logic        b_start = 1'b0, b_end_next = 1'b0;
    logic        b_en, b_end, b_wr, b_stn, b_busy;
    logic [4:0]  b_addr;
    logic [3:0]  b_waddr;
    logic [15:0] b_din = '0;
    logic [15:0] b_dout;
    logic [0:0]  b_sel;

    poolb_gen #(
        .DATA_WIDTH      (DW),
        .IFM_SIZE        (4),
        .IFM_DEPTH       (3),
        .KERNAL_SIZE     (2),
        .STRIDE          (2),
        .NUMBER_OF_UNITS (2),
        .AVG_ENABLE      (1'b1)
    ) u_dut_a (
        .clk                      (clk),
        .reset                    (reset),
        .start_from_previous      (a_start),
        .pool_mode                (a_mode),
        .data_in_from_previous    (a_din),
        .ifm_enable_read_current  (a_en),
        .ifm_address_read_current (a_addr),
        .end_to_previous          (a_end),
        .conv_ready               (a_conv_ready),
        .end_from_next            (a_end_next),
        .ifm_enable_write_next    (a_wr),
        .ifm_address_write_next   (a_waddr),
        .data_out_for_next        (a_dout),
        .ifm_sel_next             (a_sel),
        .start_to_next            (a_stn),
        .busy                     (a_busy)
    );

    poolb_gen #(
        .DATA_WIDTH      (DW),
        .IFM_SIZE        (5),
        .IFM_DEPTH       (1),
        .KERNAL_SIZE     (3),
        .STRIDE          (1),
        .NUMBER_OF_UNITS (1),
        .AVG_ENABLE      (1'b0)
    ) u_dut_b (
        .clk                      (clk),
        .reset                    (reset),
        .start_from_previous      (b_start),
        .pool_mode                (1'b0),
        .data_in_from_previous    (b_din),
        .ifm_enable_read_current  (b_en),
        .ifm_address_read_current (b_addr),
        .end_to_previous          (b_end),
        .conv_ready               (1'b1),
        .end_from_next            (b_end_next),
        .ifm_enable_write_next    (b_wr),
        .ifm_address_write_next   (b_waddr),
        .data_out_for_next        (b_dout),
        .ifm_sel_next             (b_sel),
        .start_to_next            (b_stn),
        .busy                     (b_busy)
    );

    int memA[2][32];
    int memB[32];

    // Upstream memories: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (a_en) a_din <= {DW'(memA[1][a_addr]), DW'(memA[0][a_addr])};
        if (b_en) b_din <= DW'(memB[b_addr]);
    end

    typedef struct {
        int addr;
        int sel;
        int d0;
        int d1;
        int cyc;
    } wr_t;

    wr_t a_wq[$];
    wr_t b_wq[$];
    int  cyc = 0;
    int  a_end_cnt = 0, a_stn_cnt = 0, a_rd_cnt = 0, a_first_rd = -1;
    int  a_end_cyc = 0, a_stn_cyc = 0;
    int  b_stn_cnt = 0;
    int  n_cmp = 0, n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (a_en) begin
            if (a_first_rd < 0) a_first_rd = cyc;
            a_rd_cnt++;
        end
        if (a_end) begin a_end_cnt++; a_end_cyc = cyc; end
        if (a_stn) begin a_stn_cnt++; a_stn_cyc = cyc; end
        if (a_wr) begin
            w = '{int'(a_waddr), int'(a_sel), int'($signed(a_dout[15:0])),
                  int'($signed(a_dout[31:16])), cyc};
            a_wq.push_back(w);
        end
        if (b_stn) b_stn_cnt++;
        if (b_wr) begin
            w = '{int'(b_waddr), int'(b_sel), int'($signed(b_dout)), 0, cyc};
            b_wq.push_back(w);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Window-level reference: max or floor(mean) of the K x K samples; absent channels give 0.
    function automatic int pool_ref(input bit is_b, input int lane, input int g, input int r,
                                    input int c, input logic mode);
        int n, k, s, u, depth, v, best;
        longint sum, q;
        n = is_b ? 5 : 4;
        k = is_b ? 3 : 2;
        s = is_b ? 1 : 2;
        u = is_b ? 1 : 2;
        depth = is_b ? 1 : 3;
        if (g * u + lane >= depth) return 0;
        sum = 0;
        best = 0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                v = is_b ? memB[(r * s + i) * n + c * s + j]
                         : memA[lane][g * n * n + (r * s + i) * n + c * s + j];
                sum += v;
                if ((i == 0 && j == 0) || v > best) best = v;
            end
        end
        if (mode == 1'b1) begin
            q = sum / (k * k);
            if ((sum % (k * k)) != 0 && sum < 0) q--;
            return int'(q);
        end
        return best;
    endfunction

    function automatic int cur(input int what);
        case (what)
            0: return a_stn_cnt;
            1: return a_end_cnt;
            2: return a_rd_cnt;
            3: return b_stn_cnt;
            default: return 0;
        endcase
    endfunction

    task automatic wait_for(input string name, input int what, input int target);
        int t = 0;
        while (cur(what) < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_timeout"}, int'(cur(what) >= target), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic pulse_end_a();
        a_end_next = 1'b1;
        tick();
        a_end_next = 1'b0;
    endtask

    task automatic clear_a();
        a_wq.delete();
        a_end_cnt = 0;
        a_stn_cnt = 0;
        a_rd_cnt = 0;
        a_first_rd = -1;
    endtask

    task automatic fill_random_a();
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < 32; a++) memA[l][a] = int'($urandom_range(65535)) - 32768;
    endtask

    task automatic run_pass_a(input logic mode);
        a_mode = mode;
        pulse_start_a();
        wait_for("a_pass_done", 0, a_stn_cnt + 1);
        tick();
        pulse_end_a();
    endtask

    // Compares one pass worth of writes (order g, r, c) starting at queue index base.
    task automatic check_pass_a(input string tag, input logic mode, input int base);
        for (int k = 0; k < 8; k++) begin
            int g, r, c;
            g = k / 4;
            r = (k % 4) / 2;
            c = k % 2;
            if (base + k < a_wq.size()) begin
                check({tag, "_addr"}, a_wq[base + k].addr, r * 2 + c);
                check({tag, "_sel"}, a_wq[base + k].sel, g);
                check({tag, "_lane0"}, a_wq[base + k].d0, pool_ref(1'b0, 0, g, r, c, mode));
                check({tag, "_lane1"}, a_wq[base + k].d1, pool_ref(1'b0, 1, g, r, c, mode));
            end
        end
    endtask

    typedef struct {
        logic mode;
        int   v0, v1, v2, v3;
        int   exp;
    } vec_t;

    vec_t vt[8];
    int   ramp_max[4];
    int   ramp_avg[4];

    initial begin
        int rd_seen;

        vt[0] = '{1'b0, -3, -1, -8, -2, -1};
        vt[1] = '{1'b1, -3, -1, -8, -2, -4};
        vt[2] = '{1'b1, 32767, 32767, 32767, 32767, 32767};
        vt[3] = '{1'b1, -32768, -32768, -32768, -32768, -32768};
        vt[4] = '{1'b0, -32768, -32768, -32768, -32767, -32767};
        vt[5] = '{1'b1, -1, 0, 0, 0, -1};
        vt[6] = '{1'b1, 1, 2, 3, 5, 2};
        vt[7] = '{1'b0, 7, 100, -100, 32767, 32767};
        ramp_max = '{5, 7, 13, 15};
        ramp_avg = '{2, 4, 10, 12};

        repeat (3) tick();
        @(negedge clk);
        check("reset_a_outputs", int'(|{a_en, a_addr, a_end, a_wr, a_waddr, a_dout, a_sel,
                                        a_stn, a_busy}), 0);
        check("reset_b_outputs", int'(|{b_en, b_addr, b_end, b_wr, b_waddr, b_dout, b_sel,
                                        b_stn, b_busy}), 0);
        tick();
        reset = 1'b0;
        tick();

        // Address ramp in channel 0, max then average.
        for (int m = 0; m < 2; m++) begin
            for (int l = 0; l < 2; l++)
                for (int a = 0; a < 32; a++) memA[l][a] = (l == 0 && a < 16) ? a : 0;
            clear_a();
            run_pass_a(m[0]);
            check("ramp_wr_count", a_wq.size(), 8);
            for (int k = 0; k < 4; k++)
                if (k < a_wq.size())
                    check("ramp_value", a_wq[k].d0, (m == 0) ? ramp_max[k] : ramp_avg[k]);
            check_pass_a("ramp", m[0], 0);
            check("ramp_end_pulses", a_end_cnt, 1);
            check("ramp_start_pulses", a_stn_cnt, 1);
            check("ramp_end_before_start", int'(a_end_cyc < a_stn_cyc), 1);
            if (a_wq.size() > 0) check("first_write_latency", a_wq[0].cyc - a_first_rd, 5);
            if (a_wq.size() > 7) check("group1_lane1_zero", a_wq[7].d1, 0);
        end

        // Hand-picked windows in channel 0, position (0,0).
        for (int v = 0; v < 8; v++) begin
            fill_random_a();
            memA[0][0] = vt[v].v0;
            memA[0][1] = vt[v].v1;
            memA[0][4] = vt[v].v2;
            memA[0][5] = vt[v].v3;
            clear_a();
            run_pass_a(vt[v].mode);
            check("vec_wr_count", a_wq.size(), 8);
            if (a_wq.size() > 0) check("vec_window", a_wq[0].d0, vt[v].exp);
            check_pass_a("vec_pass", vt[v].mode, 0);
        end

        // Random maps and modes.
        for (int p = 0; p < 6; p++) begin
            logic m;
            m = 1'($urandom_range(1));
            fill_random_a();
            clear_a();
            run_pass_a(m);
            check("rand_wr_count", a_wq.size(), 8);
            check_pass_a("rand", m, 0);
        end

        // Starts during RUN collapse into one pending start, gated by the next layer.
        fill_random_a();
        clear_a();
        a_conv_ready = 1'b0;
        a_mode = 1'b0;
        pulse_start_a();
        repeat (4) tick();
        pulse_start_a();
        tick();
        pulse_start_a();
        wait_for("hs_end", 1, 1);
        repeat (20) @(negedge clk);
        check("hs_hold_busy", int'(a_busy), 1);
        check("hs_hold_no_start", a_stn_cnt, 0);
        tick();
        a_conv_ready = 1'b1;
        wait_for("hs_start1", 0, 1);
        rd_seen = a_rd_cnt;
        check("hs_pass1_reads", rd_seen, 32);
        repeat (10) @(negedge clk);
        check("hs_pending_blocked", a_rd_cnt, rd_seen);
        tick();
        pulse_end_a();
        wait_for("hs_second_pass", 2, rd_seen + 1);
        wait_for("hs_start2", 0, 2);
        tick();
        pulse_end_a();
        repeat (10) @(negedge clk);
        check("hs_collapsed_reads", a_rd_cnt, 64);
        check("hs_wr_count", a_wq.size(), 16);
        check_pass_a("hs_pass1", 1'b0, 0);
        check_pass_a("hs_pass2", 1'b0, 8);

        // Reset in the middle of a pass.
        fill_random_a();
        clear_a();
        tick();
        pulse_start_a();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", int'(|{a_en, a_addr, a_end, a_wr, a_waddr, a_dout,
                                             a_sel, a_stn, a_busy}), 0);
        rd_seen = a_rd_cnt;
        repeat (60) @(negedge clk);
        check("midrun_no_start", a_stn_cnt, 0);
        check("midrun_no_end", a_end_cnt, 0);
        check("midrun_no_restart", a_rd_cnt, rd_seen);
        tick();
        clear_a();
        run_pass_a(1'b1);
        check("post_reset_wr_count", a_wq.size(), 8);
        check_pass_a("post_reset", 1'b1, 0);

        // K=3, S=1 instance: 9 windows, one write every 9 cycles.
        for (int a = 0; a < 32; a++) memB[a] = int'($urandom_range(65535)) - 32768;
        b_wq.delete();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_for("b_done", 3, 1);
        tick();
        b_end_next = 1'b1;
        tick();
        b_end_next = 1'b0;
        check("b_wr_count", b_wq.size(), 9);
        for (int k = 0; k < 9; k++) begin
            if (k < b_wq.size()) begin
                check("b_addr", b_wq[k].addr, k);
                check("b_value", b_wq[k].d0, pool_ref(1'b1, 0, 0, k / 3, k % 3, 1'b0));
                if (k > 0) check("b_spacing", b_wq[k].cyc - b_wq[k - 1].cyc, 9);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
